// File: rtl/pulse_stretch_mc_if.sv
// pulse_stretch_mc_if: per-channel event, stretched-pulse and status signals of the pulse stretcher
interface pulse_stretch_mc_if #(parameter int CH = 4);
  logic [CH-1:0] pulse_i;
  logic          ovf_clr_i;
  logic [CH-1:0] stretch_o;
  logic [CH-1:0] busy_o;
  logic [CH-1:0] ovf_o;
  modport master (output pulse_i, ovf_clr_i, input stretch_o, busy_o, ovf_o);
  modport slave  (input pulse_i, ovf_clr_i, output stretch_o, busy_o, ovf_o);
endinterface

// File: rtl/pulse_stretch_mc.sv
// pulse_stretch_mc: multi-channel pulse stretcher with event queueing; PSTR_OVF_STATUS_EN enables sticky overflow flags
module pulse_stretch_mc #(
  parameter int CH       = 4,
  parameter int HIGH_CYC = 4,
  parameter int GAP_CYC  = 4,
  parameter int PEND_W   = 3
) (
  input logic clk,
  input logic rstn,
  pulse_stretch_mc_if.slave bus
);
  localparam int MX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int CW = $clog2(MX + 1);
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [CW-1:0] H_END = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] G_END = CW'(GAP_CYC - 1);
  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
  state_t            state_q [CH];
  state_t            state_d [CH];
  logic [CW-1:0]     cnt_q   [CH];
  logic [CW-1:0]     cnt_d   [CH];
  logic [PEND_W-1:0] pend_q  [CH];
  logic [PEND_W-1:0] pend_d  [CH];
  logic [CH-1:0]     drop;
  logic [CH-1:0]     stretch_q, stretch_d;
  logic [CH-1:0]     busy_q, busy_d;
  logic [CH-1:0]     ovf_q, ovf_d;
  // state register: everything clears asynchronously so an active pulse is cut at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      stretch_q <= '0;
      busy_q    <= '0;
      ovf_q     <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
      stretch_q <= stretch_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end
  // next state: a pulse landing on the end-of-gap edge is consumed directly, so pending never lingers in IDLE
  always_comb begin
    logic ge, rl, p;
    ge = 1'b0;
    rl = 1'b0;
    p  = 1'b0;
    drop = '0;
    for (int i = 0; i < CH; i++) begin
      p  = bus.pulse_i[i];
      ge = state_q[i] == GAP && cnt_q[i] == G_END;
      rl = ge && (pend_q[i] != '0 || p);
      case (state_q[i])
        IDLE:    state_d[i] = p ? HIGH : IDLE;
        HIGH:    state_d[i] = cnt_q[i] == H_END ? GAP : HIGH;
        GAP:     state_d[i] = ge ? (rl ? HIGH : IDLE) : GAP;
        default: state_d[i] = IDLE;
      endcase
      cnt_d[i] = (state_d[i] != state_q[i] || state_q[i] == IDLE) ? '0 : cnt_q[i] + 1'b1;
      drop[i]  = state_q[i] != IDLE && !ge && p && pend_q[i] == PMAX;
      pend_d[i] = ge ? (pend_q[i] != '0 ? pend_q[i] - PEND_W'(!p) : '0)
                : (state_q[i] != IDLE && p && pend_q[i] != PMAX) ? pend_q[i] + 1'b1
                : pend_q[i];
    end
  end
  // outputs: registered from next state so nothing combinational reaches the pins
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      stretch_d[i] = state_d[i] == HIGH;
      busy_d[i]    = state_d[i] != IDLE || pend_d[i] != '0;
    end
`ifdef PSTR_OVF_STATUS_EN
    ovf_d = drop | (ovf_q & ~{CH{bus.ovf_clr_i}});
`else
    ovf_d = '0;
`endif
  end
`ifndef PSTR_OVF_STATUS_EN
  logic unused_ovf;
  assign unused_ovf = ^{bus.ovf_clr_i, drop};
`endif
  assign bus.stretch_o = stretch_q;
  assign bus.busy_o    = busy_q;
  assign bus.ovf_o     = ovf_q;
endmodule
